// File: rtl/reg_dst_mux.sv
// reg_dst_mux: registered rt/rd destination selector with qualified write enable.
// Define REGDST_LINK_EN to let `link` force LINK_ADDR (JAL/JALR to $ra).
module reg_dst_mux #(
    parameter int ADDR_W    = 6,
    parameter int LINK_ADDR = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic              RegDst,
    input  logic              link,
    input  logic              reg_write,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] sel_addr,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_en
);

    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_ADDR);

    logic              link_eff;
    logic              wen_next;
    logic [ADDR_W-1:0] write_addr_d, write_addr_q;
    logic              write_en_d, write_en_q;

`ifdef REGDST_LINK_EN
    assign link_eff = link;
`else
    // Port kept so the pin list is identical in both builds.
    assign link_eff = link & 1'b0;
`endif

    always_comb begin
        sel_addr = RegDst ? addr_2 : addr_1;
        if (link_eff) begin
            sel_addr = LINK_A;
        end
        wen_next = reg_write && (sel_addr != '0);
    end

    // Flush beats stall so a killed instruction never lingers as a hold.
    always_comb begin
        write_addr_d = write_addr_q;
        write_en_d   = write_en_q;
        if (flush) begin
            write_addr_d = '0;
            write_en_d   = 1'b0;
        end else if (!stall) begin
            write_addr_d = sel_addr;
            write_en_d   = wen_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_addr_q <= '0;
            write_en_q   <= 1'b0;
        end else begin
            write_addr_q <= write_addr_d;
            write_en_q   <= write_en_d;
        end
    end

    assign write_addr = write_addr_q;
    assign write_en   = write_en_q;

endmodule

// File: tb/tb_reg_dst_mux.sv
// tb_reg_dst_mux: scoreboard bench for reg_dst_mux, directed plus randomized sweep.
// Honours REGDST_LINK_EN the same way as the design build.
module tb_reg_dst_mux;

    localparam int AW   = 6;
    localparam int LINK = 31;

`ifdef REGDST_LINK_EN
    localparam bit LINK_ON = 1'b1;
`else
    localparam bit LINK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, RegDst, link, reg_write, stall, flush;
    logic [AW-1:0] addr_1, addr_2, sel_addr, write_addr;
    logic          write_en;

    always #5 clk = ~clk;

    reg_dst_mux #(.ADDR_W(AW), .LINK_ADDR(LINK)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_1     (addr_1),
        .addr_2     (addr_2),
        .RegDst     (RegDst),
        .link       (link),
        .reg_write  (reg_write),
        .stall      (stall),
        .flush      (flush),
        .sel_addr   (sel_addr),
        .write_addr (write_addr),
        .write_en   (write_en)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic          en;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: what the writeback registers should hold.
    int m_addr = 0;
    bit m_en   = 1'b0;

    function automatic int pick(int a1, int a2, bit rd, bit lk);
        if (LINK_ON && lk) return LINK % (1 << AW);
        return rd ? a2 : a1;
    endfunction

    task automatic step(input bit r, input int a1, input int a2, input bit rd,
                        input bit lk, input bit rw, input bit st, input bit fl);
        int   es;
        exp_t e;
        rst       = r;
        addr_1    = a1[AW-1:0];
        addr_2    = a2[AW-1:0];
        RegDst    = rd;
        link      = lk;
        reg_write = rw;
        stall     = st;
        flush     = fl;
        #1;
        es = pick(a1, a2, rd, lk);
        checks++;
        if (sel_addr !== es[AW-1:0]) begin
            failures++;
            $display("FAIL sel_addr got=%0d want=%0d", sel_addr, es);
        end
        if (r || fl) begin
            m_addr = 0;
            m_en   = 1'b0;
        end else if (!st) begin
            m_addr = es;
            m_en   = rw && (es != 0);
        end
        e.a  = m_addr[AW-1:0];
        e.en = m_en;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (write_addr !== e.a || write_en !== e.en) begin
                    failures++;
                    $display("FAIL wb_regs got=%0d/%0b want=%0d/%0b",
                             write_addr, write_en, e.a, e.en);
                end
            end
        end
    end

    initial begin
        // reset held two cycles, then first load
        step(1, 5, 0, 0, 0, 1, 0, 0);
        step(1, 5, 0, 0, 0, 1, 0, 0);
        step(0, 5, 0, 0, 0, 1, 0, 0);
        // rt / rd select
        step(0, 8, 17, 0, 0, 1, 0, 0);
        step(0, 8, 17, 1, 0, 1, 0, 0);
        // register 0 suppression, then reg_write low
        step(0, 8, 0, 1, 0, 1, 0, 0);
        step(0, 8, 9, 1, 0, 0, 0, 0);
        // stall holds 12/1, then flush wins over stall
        step(0, 12, 0, 0, 0, 1, 0, 0);
        step(0, 3, 0, 0, 0, 1, 1, 0);
        step(0, 3, 0, 0, 0, 1, 1, 0);
        step(0, 3, 0, 0, 0, 1, 1, 0);
        step(0, 3, 0, 0, 0, 1, 1, 1);
        // reset during stall, hold continues with cleared values
        step(0, 7, 0, 0, 0, 1, 0, 0);
        step(1, 7, 0, 0, 0, 1, 1, 0);
        step(0, 7, 0, 0, 0, 1, 1, 0);
        // link override
        step(0, 0, 4, 1, 1, 1, 0, 0);
        step(0, 6, 4, 0, 1, 1, 0, 0);
        // randomized sweeps across every value of each address
        for (int i = 0; i < 64; i++) begin
            step($urandom_range(0, 31) == 0, i, $urandom_range(0, 63),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
        end
        for (int i = 0; i < 64; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 63), i,
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_dst_mux.md
# reg_dst_mux

Registered destination-register selector for the MIPS datapath. It picks the register-file write address from the instruction's rt field (`addr_1`) or rd field (`addr_2`) under `RegDst`, with an optional jump-and-link override to the link register. The selected address and a qualified write enable are registered for the writeback stage. Stall and flush controls come from the pipeline hazard unit.

## Interface
Parameters:
- `ADDR_W`, default 6: width of every register address.
- `LINK_ADDR`, default 31: address forced when `link` is asserted.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous active-high reset.
- `addr_1`  input  ADDR_W  rt field (I-type destination).
- `addr_2`  input  ADDR_W  rd field (R-type destination).
- `RegDst`  input  1  0 selects `addr_1`; 1 selects `addr_2`.
- `link`  input  1  forces `LINK_ADDR`. Only honoured when `REGDST_LINK_EN` is defined.
- `reg_write`  input  1  instruction writes the register file.
- `stall`  input  1  holds the registered outputs.
- `flush`  input  1  kills the registered instruction (bubble).
- `sel_addr`  output  ADDR_W  combinational selected address, not registered.
- `write_addr`  output  ADDR_W  registered destination address.
- `write_en`  output  1  registered, qualified write enable.

## Operation
- Selection, combinational: `sel_addr = link_eff ? LINK_ADDR : (RegDst ? addr_2 : addr_1)`.
- `link_eff = link` when `REGDST_LINK_EN` is defined, otherwise 0.
- Write qualification: `wen_next = reg_write && (sel_addr != 0)`. Writes to register 0 are always suppressed.
- Register update on each rising `clk`, highest priority first:
  - `rst`: `write_addr <= 0`, `write_en <= 0`.
  - `flush`: `write_addr <= 0`, `write_en <= 0`.
  - `stall`: both outputs hold their current value.
  - otherwise: `write_addr <= sel_addr`, `write_en <= wen_next`.
- `flush` and `stall` asserted together: `flush` wins and a bubble is inserted.
- `LINK_ADDR` is truncated to ADDR_W bits. If `LINK_ADDR` is 0, a link write is suppressed like any other write to register 0.
- Inputs are sampled only at the clock edge. No internal state exists beyond the two output registers.

## Timing
- `sel_addr`: zero-cycle combinational path from `addr_1`, `addr_2`, `RegDst` and `link`.
- `write_addr` / `write_en`: 1-cycle latency from the inputs.
- Reset values: `write_addr = 0`, `write_en = 0`. They take effect at the first rising edge with `rst` high. Before that first edge the outputs are undefined.
- Deasserting `rst`: the first load happens on the next edge where `rst`, `flush` and `stall` are all low.
- Reset mid-stall: the reset clears the outputs. Stall-hold resumes afterwards with the cleared values.
- No handshake. The upstream stage must keep its inputs stable while `stall` is high; the held outputs do not track input changes during a stall.

## Configuration
- Macro: `REGDST_LINK_EN`.
- Defined: `link = 1` forces `sel_addr = LINK_ADDR`, overriding `RegDst`. This supports JAL/JALR writes to `$ra`.
- Not defined: the `link` port is still present but ignored. Selection depends only on `RegDst`, and the port list does not change between builds.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `addr_1` = 5, `reg_write` = 1 → `write_addr` = 0 and `write_en` = 0; release → next edge gives `write_addr` = 5, `write_en` = 1.
- Select: `addr_1` = 8, `addr_2` = 17, `reg_write` = 1; `RegDst` = 0 → `write_addr` = 8 one cycle later; `RegDst` = 1 → `write_addr` = 17. `sel_addr` changes in the same cycle as `RegDst`.
- Zero suppression: `RegDst` = 1, `addr_2` = 0, `reg_write` = 1 → `write_addr` = 0, `write_en` = 0. Then `reg_write` = 0 with `addr_2` = 9 → `write_addr` = 9, `write_en` = 0.
- Stall/flush: load 12 with `write_en` = 1, then `stall` = 1 and change `addr_1` to 3 → outputs stay 12/1 for 3 cycles. Then `stall` = `flush` = 1 → outputs 0/0.
- Link: `link` = 1, `RegDst` = 1, `addr_2` = 4, `reg_write` = 1 → with `REGDST_LINK_EN` defined, `write_addr` = 31; without it, `write_addr` = 4.
- Exhaustive: sweep all 64 values of each address with random `RegDst`, `reg_write`, `stall` and `flush` against a reference model → zero mismatches.
